// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the RV32 pipeline sequencer.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {BOOT, RUN, LDUSE, HALT} pipe_state_e;

   localparam int unsigned REG_IDX_W = 5;
   localparam int unsigned PERF_W    = 32;

   function automatic int unsigned cnt_width(input int unsigned max_cnt);
      return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
   endfunction

   // Wide enough for the largest legal LOAD_STALL; modules widen further if needed.
   localparam int unsigned CNT_W = cnt_width(7);

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decode/EX-side bundle for the pipeline sequencer: hazard inputs, controls, perf counters.
interface pipe_ctrl_if;
   import pipe_ctrl_pkg::*;

   logic [REG_IDX_W-1:0] dec_rs1;
   logic [REG_IDX_W-1:0] dec_rs2;
   logic                 dec_use_rs1;
   logic                 dec_use_rs2;
   logic                 ex_valid;
   logic                 ex_mem_read;
   logic [REG_IDX_W-1:0] ex_rd;
   logic                 ex_br_taken;
   logic                 halt_req;
   logic                 stall;
   logic                 flush_fd;
   logic                 flush_de;
   logic                 halted;
   logic [PERF_W-1:0]    perf_cycles;
   logic [PERF_W-1:0]    perf_stalls;
   logic [PERF_W-1:0]    perf_flushes;

   modport master (
      output dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
      output ex_valid, ex_mem_read, ex_rd, ex_br_taken, halt_req,
      input  stall, flush_fd, flush_de, halted,
      input  perf_cycles, perf_stalls, perf_flushes
   );

   modport slave (
      input  dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
      input  ex_valid, ex_mem_read, ex_rd, ex_br_taken, halt_req,
      output stall, flush_fd, flush_de, halted,
      output perf_cycles, perf_stalls, perf_flushes
   );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the decode operands and the load sitting in EX.
module pipe_ctrl_hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_IDX_W-1:0] dec_rs1_i,
   input  logic [REG_IDX_W-1:0] dec_rs2_i,
   input  logic                 dec_use_rs1_i,
   input  logic                 dec_use_rs2_i,
   input  logic                 ex_valid_i,
   input  logic                 ex_mem_read_i,
   input  logic [REG_IDX_W-1:0] ex_rd_i,
   output logic                 hazard_o
);

   logic rs1_match;
   logic rs2_match;

   assign rs1_match = dec_use_rs1_i && (dec_rs1_i == ex_rd_i);
   assign rs2_match = dec_use_rs2_i && (dec_rs2_i == ex_rd_i);

   // x0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign hazard_o = ex_valid_i && ex_mem_read_i && (ex_rd_i != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: boot hold, load-use interlock, branch flush and halt/drain.
// Define PIPE_CTRL_PERF_EN to build the cycle/stall/flush performance counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned BOOT_CYCLES  = 4,
   parameter int unsigned LOAD_STALL   = 1,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rstn,
   pipe_ctrl_if.slave  bus
);

   localparam int unsigned MaxCnt = (BOOT_CYCLES > LOAD_STALL) ?
                                    ((BOOT_CYCLES > DRAIN_CYCLES) ? BOOT_CYCLES : DRAIN_CYCLES) :
                                    ((LOAD_STALL > DRAIN_CYCLES) ? LOAD_STALL : DRAIN_CYCLES);
   localparam int unsigned CntW   = (cnt_width(MaxCnt) > CNT_W) ? cnt_width(MaxCnt) : CNT_W;

   pipe_state_e     state_q, state_d;
   logic [CntW-1:0] boot_cnt_q, boot_cnt_d;
   logic [CntW-1:0] ld_cnt_q, ld_cnt_d;
   logic [CntW-1:0] drain_cnt_q, drain_cnt_d;
   logic            halted_q, halted_d;
   logic            hazard;
   logic            stall, flush_fd, flush_de;
   logic            br_flush;

   pipe_ctrl_hazard_detect u_hazard_detect (
      .dec_rs1_i     (bus.dec_rs1),
      .dec_rs2_i     (bus.dec_rs2),
      .dec_use_rs1_i (bus.dec_use_rs1),
      .dec_use_rs2_i (bus.dec_use_rs2),
      .ex_valid_i    (bus.ex_valid),
      .ex_mem_read_i (bus.ex_mem_read),
      .ex_rd_i       (bus.ex_rd),
      .hazard_o      (hazard)
   );

   always_comb begin
      state_d     = state_q;
      boot_cnt_d  = boot_cnt_q;
      ld_cnt_d    = ld_cnt_q;
      drain_cnt_d = drain_cnt_q;
      stall       = 1'b0;
      flush_fd    = 1'b0;
      flush_de    = 1'b0;
      unique case (state_q)
         BOOT: begin
            stall    = 1'b1;
            flush_fd = 1'b1;
            flush_de = 1'b1;
            if (boot_cnt_q == CntW'(BOOT_CYCLES - 1)) begin
               state_d    = RUN;
               boot_cnt_d = '0;
            end else begin
               boot_cnt_d = boot_cnt_q + CntW'(1);
            end
         end
         RUN: begin
            // A taken branch squashes the dependent instruction, so it never stalls.
            if (bus.ex_br_taken) begin
               flush_fd = 1'b1;
               flush_de = 1'b1;
            end else if (hazard) begin
               stall    = 1'b1;
               flush_de = 1'b1;
               if (LOAD_STALL > 1) begin
                  state_d  = LDUSE;
                  ld_cnt_d = CntW'(1);
               end
            end else if (bus.halt_req) begin
               state_d     = HALT;
               drain_cnt_d = '0;
            end
         end
         LDUSE: begin
            if (bus.ex_br_taken) begin
               flush_fd = 1'b1;
               flush_de = 1'b1;
               state_d  = RUN;
               ld_cnt_d = '0;
            end else begin
               stall    = 1'b1;
               flush_de = 1'b1;
               if ((ld_cnt_q + CntW'(1)) == CntW'(LOAD_STALL)) begin
                  state_d  = RUN;
                  ld_cnt_d = '0;
               end else begin
                  ld_cnt_d = ld_cnt_q + CntW'(1);
               end
            end
         end
         HALT: begin
            stall    = 1'b1;
            flush_de = 1'b1;
            flush_fd = bus.ex_br_taken;
            if (drain_cnt_q != CntW'(DRAIN_CYCLES)) begin
               drain_cnt_d = drain_cnt_q + CntW'(1);
            end
            if (!bus.halt_req) begin
               state_d     = RUN;
               drain_cnt_d = '0;
            end
         end
         default: state_d = BOOT;
      endcase
      halted_d = (state_d == HALT) && (drain_cnt_d == CntW'(DRAIN_CYCLES));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= BOOT;
         boot_cnt_q  <= '0;
         ld_cnt_q    <= '0;
         drain_cnt_q <= '0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         boot_cnt_q  <= boot_cnt_d;
         ld_cnt_q    <= ld_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         halted_q    <= halted_d;
      end
   end

   assign br_flush     = bus.ex_br_taken && (state_q != BOOT);
   assign bus.stall    = stall;
   assign bus.flush_fd = flush_fd;
   assign bus.flush_de = flush_de;
   assign bus.halted   = halted_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [PERF_W-1:0] perf_cycles_q, perf_cycles_d;
   logic [PERF_W-1:0] perf_stalls_q, perf_stalls_d;
   logic [PERF_W-1:0] perf_flushes_q, perf_flushes_d;

   always_comb begin
      perf_cycles_d  = perf_cycles_q + PERF_W'(1);
      perf_stalls_d  = perf_stalls_q + PERF_W'(stall && (state_q != BOOT));
      perf_flushes_d = perf_flushes_q + PERF_W'(br_flush);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         perf_cycles_q  <= '0;
         perf_stalls_q  <= '0;
         perf_flushes_q <= '0;
      end else begin
         perf_cycles_q  <= perf_cycles_d;
         perf_stalls_q  <= perf_stalls_d;
         perf_flushes_q <= perf_flushes_d;
      end
   end

   assign bus.perf_cycles  = perf_cycles_q;
   assign bus.perf_stalls  = perf_stalls_q;
   assign bus.perf_flushes = perf_flushes_q;
`else
   logic unused_br_flush;
   assign unused_br_flush  = br_flush;
   assign bus.perf_cycles  = '0;
   assign bus.perf_stalls  = '0;
   assign bus.perf_flushes = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default build (u_dut) and a LOAD_STALL=3 build (u_dut3).
module tb_pipe_ctrl;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   pipe_ctrl_if if_a ();
   pipe_ctrl_if if_b ();

   pipe_ctrl u_dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (if_a)
   );

   pipe_ctrl #(.LOAD_STALL(3)) u_dut3 (
      .clk  (clk),
      .rstn (rstn),
      .bus  (if_b)
   );

   always #5 clk = ~clk;

   logic [2:0] ctl_a, ctl_b;
   assign ctl_a = {if_a.stall, if_a.flush_fd, if_a.flush_de};
   assign ctl_b = {if_b.stall, if_b.flush_fd, if_b.flush_de};

   task automatic idle();
      if_a.dec_rs1 = '0; if_a.dec_rs2 = '0; if_a.dec_use_rs1 = 0; if_a.dec_use_rs2 = 0;
      if_a.ex_valid = 0; if_a.ex_mem_read = 0; if_a.ex_rd = '0;
      if_a.ex_br_taken = 0; if_a.halt_req = 0;
      if_b.dec_rs1 = '0; if_b.dec_rs2 = '0; if_b.dec_use_rs1 = 0; if_b.dec_use_rs2 = 0;
      if_b.ex_valid = 0; if_b.ex_mem_read = 0; if_b.ex_rd = '0;
      if_b.ex_br_taken = 0; if_b.halt_req = 0;
   endtask

   task automatic hz(input bit sel, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic v, input logic mr,
                     input logic [4:0] rd);
      if (sel) begin
         if_b.dec_rs1 = rs1; if_b.dec_rs2 = rs2; if_b.dec_use_rs1 = u1; if_b.dec_use_rs2 = u2;
         if_b.ex_valid = v; if_b.ex_mem_read = mr; if_b.ex_rd = rd;
      end else begin
         if_a.dec_rs1 = rs1; if_a.dec_rs2 = rs2; if_a.dec_use_rs1 = u1; if_a.dec_use_rs2 = u2;
         if_a.ex_valid = v; if_a.ex_mem_read = mr; if_a.ex_rd = rd;
      end
   endtask

   task automatic test_reset();
      logic exp;
      rstn = 1'b0;
      idle();
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (ctl_a !== 3'b111 || if_a.halted !== 1'b0) begin
         $display("FAIL rst_ctl: got ctl=%b halted=%b, want 111/0", ctl_a, if_a.halted);
         n_fail++;
      end
      n_checks++;
      if (ctl_b !== 3'b111) begin
         $display("FAIL rst_ctl3: got %b, want 111", ctl_b);
         n_fail++;
      end
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         exp = (i < 4);
         n_checks++;
         if (if_a.stall !== exp || if_b.stall !== exp) begin
            $display("FAIL boot_stall[%0d]: got %b/%b, want %b", i, if_a.stall, if_b.stall, exp);
            n_fail++;
         end
      end
   endtask

   task automatic test_load_use();
      logic [2:0] exp [7];
      exp = '{3'b101, 3'b000, 3'b000, 3'b101, 3'b000, 3'b000, 3'b000};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         idle();
         case (i)
            0: hz(0, 5'd5, 5'd1, 1, 1, 1, 1, 5'd5);  // lw x5 / add x6,x5,x1
            1: ;                                     // bubble follows: one stall only
            2: hz(0, 5'd0, 5'd2, 1, 0, 1, 1, 5'd0);  // load to x0
            3: hz(0, 5'd3, 5'd7, 1, 1, 1, 1, 5'd7);  // rs2 match
            4: hz(0, 5'd3, 5'd7, 1, 0, 1, 1, 5'd7);  // rs2 match but unused
            5: hz(0, 5'd5, 5'd0, 1, 0, 1, 0, 5'd5);  // not a load
            default: hz(0, 5'd5, 5'd0, 1, 0, 0, 1, 5'd5);  // EX invalid
         endcase
         #1;
         n_checks++;
         if (ctl_a !== exp[i]) begin
            $display("FAIL load_use[%0d]: got %b, want %b", i, ctl_a, exp[i]);
            n_fail++;
         end
      end
   endtask

   task automatic test_load_stall3();
      logic [2:0] exp [8];
      exp = '{3'b101, 3'b101, 3'b101, 3'b000, 3'b101, 3'b011, 3'b000, 3'b000};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         idle();
         if (i == 0 || i == 4) hz(1, 5'd5, 5'd0, 1, 0, 1, 1, 5'd5);
         if (i == 5) if_b.ex_br_taken = 1'b1;
         #1;
         n_checks++;
         if (ctl_b !== exp[i]) begin
            $display("FAIL ld_stall3[%0d]: got %b, want %b", i, ctl_b, exp[i]);
            n_fail++;
         end
      end
   endtask

   task automatic test_branch_hazard();
      @(negedge clk);
      idle();
      hz(0, 5'd5, 5'd0, 1, 0, 1, 1, 5'd5);
      hz(1, 5'd5, 5'd0, 1, 0, 1, 1, 5'd5);
      if_a.ex_br_taken = 1'b1;
      if_b.ex_br_taken = 1'b1;
      #1;
      n_checks++;
      if (ctl_a !== 3'b011 || ctl_b !== 3'b011) begin
         $display("FAIL br_hazard: got %b/%b, want 011", ctl_a, ctl_b);
         n_fail++;
      end
      @(negedge clk);
      idle();
      #1;
      n_checks++;
      if (ctl_a !== 3'b000 || ctl_b !== 3'b000) begin
         $display("FAIL br_hazard_after: got %b/%b, want 000", ctl_a, ctl_b);
         n_fail++;
      end
   endtask

   task automatic test_halt();
      @(negedge clk);
      idle();
      if_a.halt_req = 1'b1;
      #1;
      n_checks++;
      if (ctl_a !== 3'b000 || if_a.halted !== 1'b0) begin
         $display("FAIL halt_entry: got ctl=%b halted=%b, want 000/0", ctl_a, if_a.halted);
         n_fail++;
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         n_checks++;
         if (ctl_a !== 3'b101 || if_a.halted !== 1'b0) begin
            $display("FAIL halt_drain[%0d]: got ctl=%b halted=%b, want 101/0", i, ctl_a,
                     if_a.halted);
            n_fail++;
         end
      end
      @(negedge clk);
      if_a.ex_br_taken = 1'b1;
      #1;
      n_checks++;
      if (ctl_a !== 3'b111 || if_a.halted !== 1'b1) begin
         $display("FAIL halt_done_br: got ctl=%b halted=%b, want 111/1", ctl_a, if_a.halted);
         n_fail++;
      end
      @(negedge clk);
      if_a.ex_br_taken = 1'b0;
      if_a.halt_req = 1'b0;
      #1;
      n_checks++;
      if (ctl_a !== 3'b101 || if_a.halted !== 1'b1) begin
         $display("FAIL halt_release: got ctl=%b halted=%b, want 101/1", ctl_a, if_a.halted);
         n_fail++;
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (ctl_a !== 3'b000 || if_a.halted !== 1'b0) begin
         $display("FAIL halt_resumed: got ctl=%b halted=%b, want 000/0", ctl_a, if_a.halted);
         n_fail++;
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      idle();
      if_a.halt_req = 1'b1;
      repeat (2) @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      n_checks++;
      if (ctl_a !== 3'b111 || if_a.halted !== 1'b0 || if_a.perf_cycles !== 32'd0) begin
         $display("FAIL async_rst: got ctl=%b halted=%b cyc=%0d, want 111/0/0", ctl_a,
                  if_a.halted, if_a.perf_cycles);
         n_fail++;
      end
      idle();
   endtask

   task automatic test_perf();
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         idle();
         if (i == 4 || i == 6) hz(0, 5'd5, 5'd0, 1, 0, 1, 1, 5'd5);
         if (i == 7) if_a.ex_br_taken = 1'b1;
      end
      #1;
      n_checks++;
`ifdef PIPE_CTRL_PERF_EN
      if (if_a.perf_cycles !== 32'd10 || if_a.perf_stalls !== 32'd2 ||
          if_a.perf_flushes !== 32'd1) begin
         $display("FAIL perf_on: got %0d/%0d/%0d, want 10/2/1", if_a.perf_cycles,
                  if_a.perf_stalls, if_a.perf_flushes);
         n_fail++;
      end
`else
      if (if_a.perf_cycles !== 32'd0 || if_a.perf_stalls !== 32'd0 ||
          if_a.perf_flushes !== 32'd0) begin
         $display("FAIL perf_off: got %0d/%0d/%0d, want 0/0/0", if_a.perf_cycles,
                  if_a.perf_stalls, if_a.perf_flushes);
         n_fail++;
      end
`endif
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_load_stall3();
      test_branch_hazard();
      test_halt();
      test_async_reset();
      test_perf();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
